// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit holding the HI/LO pair.
// Each operation runs 32 clocks; HI/LO change only when an operation retires or on MTHI/MTLO.
//
// state | meaning
// IDLE  | no operation in flight; MTHI/MTLO writes and start accepted
// RUN   | 32 shift-add / shift-subtract iterations in progress
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic        accept, finish;
  logic [5:0]  cnt;
  logic        is_div_q, neg_q, rneg_q, div0_q;
  logic [31:0] a_q, m_q, w_hi, w_lo;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum;
  logic [33:0] sub_diff;
  logic [31:0] nx_hi, nx_lo;
  logic [63:0] prod, prod_neg;
  logic [31:0] res_hi, res_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A start on the retiring edge chains straight into the next operation.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == 6'd31) begin
          finish = 1'b1;
          if (start) accept   = 1'b1;
          else       state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Signed ops run on magnitudes; the sign is reapplied at retirement.
  assign a_neg = ~op[0] & src_a[31];
  assign b_neg = ~op[0] & src_b[31];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  always_comb begin
    add_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, m_q} : 33'd0);
    sub_diff = {1'b0, w_hi, w_lo[31]} - {2'b00, m_q};
    if (is_div_q) begin
      if (!sub_diff[33]) begin
        nx_hi = sub_diff[31:0];
        nx_lo = {w_lo[30:0], 1'b1};
      end else begin
        nx_hi = {w_hi[30:0], w_lo[31]};
        nx_lo = {w_lo[30:0], 1'b0};
      end
    end else begin
      nx_hi = add_sum[32:1];
      nx_lo = {add_sum[0], w_lo[31:1]};
    end
  end

  always_comb begin
    prod     = {nx_hi, nx_lo};
    prod_neg = -prod;
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rneg_q ? -nx_hi : nx_hi;
        res_lo = neg_q  ? -nx_lo : nx_lo;
      end
    end else begin
      res_hi = neg_q ? prod_neg[63:32] : prod[63:32];
      res_lo = neg_q ? prod_neg[31:0]  : prod[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 6'd0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      a_q      <= 32'd0;
      m_q      <= 32'd0;
      w_hi     <= 32'd0;
      w_lo     <= 32'd0;
    end else begin
      done <= finish;
      if (finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (accept) begin
        cnt      <= 6'd0;
        is_div_q <= op[1];
        neg_q    <= a_neg ^ b_neg;
        rneg_q   <= a_neg;
        div0_q   <= op[1] & (src_b == 32'd0);
        a_q      <= src_a;
        w_hi     <= 32'd0;
        m_q      <= op[1] ? b_mag : a_mag;
        w_lo     <= op[1] ? a_mag : b_mag;
      end else if (state == RUN && !finish) begin
        cnt  <= cnt + 6'd1;
        w_hi <= nx_hi;
        w_lo <= nx_lo;
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops vs. an
// arithmetic reference model, and hand-written timing/corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit mt, input bit intrude,
                        input bit rel_reset, input string nm);
    logic [31:0] h0, l0;
    bit hold_ok, busy_ok, done_ok;
    hold_ok = 1; busy_ok = 1; done_ok = 1;
    @(negedge clk);
    if (rel_reset) reset = 1'b0;
    h0 = hi; l0 = lo;
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (mt) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 2'($urandom);
    chk({nm, " busy@E0"}, {63'd0, busy}, 64'd1);
    for (int k = 1; k <= 32; k++) begin
      if (intrude && k == 10) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'h1234_5678;
        src_a = 32'h7; src_b = 32'h3; op = 2'b11;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      if (k < 32) begin
        if (busy !== 1'b1) busy_ok = 0;
        if (done !== 1'b0) done_ok = 0;
        if (hi !== h0 || lo !== l0) hold_ok = 0;
      end
    end
    chk({nm, " run_busy_nodone"}, {62'd0, busy_ok, done_ok}, 64'd3);
    chk({nm, " hold"}, {63'd0, hold_ok}, 64'd1);
    chk({nm, " busy@E32"}, {63'd0, busy}, 64'd0);
    chk({nm, " done@E32"}, {63'd0, done}, 64'd1);
    chk({nm, " result"}, {hi, lo}, exp);
    @(posedge clk); #1;
    chk({nm, " done_pulse_end"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit ok;

    vt[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vt[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vt[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vt[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[6] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vt[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[9] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, hi, lo}, 66'd0);

    // First start lands on the first edge after reset release.
    run_op(2'b01, 32'd6, 32'd7, 64'd42, 0, 0, 1, "first_after_reset");

    for (int i = 0; i < 10; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, {vt[i].ehi, vt[i].elo}, 0, 0, 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op(ro, ra, rb, model(ro, ra, rb), 0, 0, 0, $sformatf("rand%0d", i));
    end

    // MTHI/MTLO while idle.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_only", {hi, lo}, {32'h1111_1111, 32'hA5A5_A5A5});

    // Start and MT in the same idle cycle: MT dropped.
    run_op(2'b01, 32'd3, 32'd5, 64'd15, 1, 0, 0, "start_beats_mt");

    // Start + MTHI at cycle 10 of a running MULT: both ignored.
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0009, model(2'b00, 32'hFFFF_FFFD, 32'h0000_0009), 0, 1, 0, "busy_intrude");

    // Back-to-back: new start accepted on the retiring edge.
    @(negedge clk);
    op = 2'b01; src_a = 32'd10; src_b = 32'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b first_result", {busy, done, hi, lo}, {1'b1, 1'b1, 32'd0, 32'd200});
    repeat (31) @(posedge clk);
    #1;
    chk("b2b still_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    chk("b2b second_result", {busy, done, hi, lo}, {1'b0, 1'b1, 32'd2, 32'd14});

    // Reset in the middle of a DIV.
    @(negedge clk);
    op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midop_reset", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    ok = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 0;
    end
    chk("after_reset_quiet", {63'd0, ok}, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
